req_encoder_16_4: RTL and testbench
===================================

// Module: req_encoder_16_4
// PURPOSE
//  Sequential 16->4 request encoder; inverse of the CPU's 4->16 one-hot decoder.
//  Latches up to 16 one-hot request lines into a pending register and picks one pending line.
//  Presents the picked index as a 4-bit code with a valid/ready handshake, then retires that line.
//  Sits between peripheral/interrupt request lines and the CPU control unit.
//  The presented code, fed back through the 4->16 decoder, yields the retired request bit.
// PARAMETERS
//  N            16  number of request lines (fixed at 16 in this revision)
//  W            4   code width, W = clog2(N)
//  ROUND_ROBIN  0   0 = fixed priority (line 0 highest); 1 = rotating priority
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req        in   16  request lines, sampled every cycle, OR-ed into pending
//  out_ready  in   1   consumer accepts out_idx when high with out_valid
//  out_valid  out  1   out_idx holds a valid pending index
//  out_idx    out  4   encoded index of the line being presented
//  pending    out  16  registered pending-request vector
//  dup_req    out  1   one-cycle pulse: req hit a line already pending (request merged)
// BEHAVIOUR
//  Reset (async, rst_n=0): pending=0, out_valid=0, out_idx=0, dup_req=0, rr_ptr=0, state=IDLE.
//  Pending update per edge: pending <= (pending & ~acc_mask) | req.
//    acc_mask = onehot(out_idx) when out_valid&&out_ready, else 0.
//    A same-cycle req on the accepted line wins: the bit stays set as a new request.
//  dup_req <= |(req & pending & ~acc_mask).
//  eligible = pending & ~acc_mask. Req bits of the current cycle are never eligible this cycle.
//  Pick: fixed priority = lowest set index of eligible.
//    Rotating = first set index at or above rr_ptr, wrapping 15->0.
//  rr_ptr <= out_idx+1 (mod 16) on each accept; unchanged otherwise; unused when ROUND_ROBIN=0.
//  FSM states: IDLE, PRESENT.
//    IDLE: if |eligible: out_idx <= pick, out_valid <= 1, go PRESENT; else stay.
//    PRESENT, !out_ready: hold out_idx and out_valid stable, even if a higher-priority line arrives.
//    PRESENT, out_ready, |eligible: out_idx <= pick, stay PRESENT (back-to-back, 1 code/cycle).
//    PRESENT, out_ready, eligible==0: out_valid <= 0, go IDLE.
//  Latency: req pulse at cycle n -> pending bit set after edge n+1 -> out_valid high after edge n+2.
//  out_valid is never high with out_idx pointing at a clear pending bit.
//  out_ready while out_valid=0 is ignored.
//  All 16 lines pending with out_ready held high: 16 codes on 16 consecutive cycles, then idle.
//  Mid-operation reset: all state cleared immediately; pending requests are lost, not replayed.
// STRUCTURE
//  Shared package cpu_pkg holds: REQ_N=16, REQ_W=4, typedef enc_state_t {IDLE,PRESENT}.
//  One sub-module: prio_pick (combinational).
//    Inputs: vec[15:0], start[3:0]. Outputs: idx[3:0], any.
//    Rotating search from start; fixed priority = start tied to 0.
//  Top holds pending, rr_ptr, FSM, output and dup_req registers; no other hierarchy.
// TESTING
//  Reset: rst_n=0 mid-stream with pending=16'hFFFF -> all outputs 0 asynchronously.
//    Then out_valid=0 until a new req.
//  Single line: req=16'h0020 for 1 cycle, ready=1 -> out_valid for exactly one cycle, 2 cycles later.
//    out_idx=5; pending returns to 0.
//  Fixed priority: req=16'h8421, ready=1 -> out_idx sequence 0,5,10,15 on consecutive cycles.
//    Each code decoded 4->16 equals the retired pending bit.
//  Backpressure: pending=16'h0010 presented (idx 4), ready=0, then req=16'h0001 -> idx stays 4.
//    After ready=1: idx 4 then idx 0.
//  Round-robin (ROUND_ROBIN=1): lines 3 and 9 held pending, ready=1, re-request each accept.
//    -> idx alternates 3,9,3,9; rr_ptr wraps 15->0 correctly.
//  Duplicate/same-cycle: req=line 7 while line 7 pending -> dup_req pulse.
//    req=line 7 in the accept cycle of idx 7 -> bit stays pending, idx 7 presented again.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared request-encoder sizes and FSM state type
package cpu_pkg;
  localparam int REQ_N = 16;
  localparam int REQ_W = 4;
  typedef enum logic {IDLE, PRESENT} enc_state_t;
endpackage

// File: rtl/req_encoder_16_4_if.sv
// req_encoder_16_4_if: request lines, code handshake and status of the request encoder
interface req_encoder_16_4_if;
  import cpu_pkg::*;
  logic [REQ_N-1:0] req;
  logic [REQ_N-1:0] pending;
  logic [REQ_W-1:0] out_idx;
  logic out_ready;
  logic out_valid;
  logic dup_req;
  modport master (input req, out_ready, output out_valid, out_idx, pending, dup_req);
  modport slave (output req, out_ready, input out_valid, out_idx, pending, dup_req);
endinterface

// File: rtl/prio_pick.sv
// prio_pick: first set bit of vec searching upward from start, wrapping to 0
module prio_pick
  import cpu_pkg::*;
(
  input  logic [REQ_N-1:0] vec,
  input  logic [REQ_W-1:0] start,
  output logic [REQ_W-1:0] idx,
  output logic             any
);
  assign any = |vec;
  always_comb begin
    idx = '0;
    for (int i = REQ_N - 1; i >= 0; i--)
      if (vec[start + REQ_W'(i)]) idx = start + REQ_W'(i);
  end
endmodule

// File: rtl/req_encoder_16_4.sv
// req_encoder_16_4: latches one-hot requests and presents one pending index per valid/ready transfer
module req_encoder_16_4
  import cpu_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input logic clk,
  input logic rst_n,
  req_encoder_16_4_if.master bus
);
  enc_state_t state, state_n;
  logic [REQ_N-1:0] pending_q, acc_mask, eligible;
  logic [REQ_W-1:0] idx_q, idx_n, rr_ptr, pick;
  logic valid_q, valid_n, dup_q, acc, any;
  assign acc = valid_q && bus.out_ready;
  assign acc_mask = acc ? REQ_N'(1) << idx_q : '0;
  assign eligible = pending_q & ~acc_mask;
  prio_pick u_pick (
    .vec  (eligible),
    .start(ROUND_ROBIN ? rr_ptr : REQ_W'(0)),
    .idx  (pick),
    .any  (any)
  );
  // Without ready the presented code is frozen, even if a higher-priority line arrives.
  always_comb begin
    state_n = state;
    idx_n = idx_q;
    valid_n = valid_q;
    if (state == IDLE || acc) begin
      state_n = any ? PRESENT : IDLE;
      valid_n = any;
      idx_n = any ? pick : idx_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      dup_q <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      pending_q <= eligible | bus.req;
      idx_q <= idx_n;
      valid_q <= valid_n;
      dup_q <= |(bus.req & eligible);
      rr_ptr <= acc ? idx_q + 1'b1 : rr_ptr;
    end
  end
  assign bus.pending = pending_q;
  assign bus.out_idx = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.dup_req = dup_q;
endmodule

// File: tb/tb_req_encoder_16_4.sv
// tb_req_encoder_16_4: directed checks of fixed-priority and rotating request encoders
module tb_req_encoder_16_4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  req_encoder_16_4_if f ();
  req_encoder_16_4_if r ();
  req_encoder_16_4 #(.ROUND_ROBIN(1'b0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(f.master));
  req_encoder_16_4 #(.ROUND_ROBIN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(r.master));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_fix(input string tag, input logic v, input logic [3:0] i, input logic [15:0] p);
    chk({tag, "_valid"}, 16'(f.out_valid), 16'(v));
    if (v) chk({tag, "_idx"}, 16'(f.out_idx), 16'(i));
    chk({tag, "_pend"}, f.pending, p);
  endtask
  task automatic chk_rr(input string tag, input logic v, input logic [3:0] i);
    chk({tag, "_valid"}, 16'(r.out_valid), 16'(v));
    if (v) chk({tag, "_idx"}, 16'(r.out_idx), 16'(i));
  endtask
  initial begin
    f.req = '0; f.out_ready = 1'b0;
    r.req = '0; r.out_ready = 1'b0;
    step(); step();
    chk_fix("reset", 1'b0, 4'd0, 16'h0000);
    chk("reset_idx", 16'(f.out_idx), 16'h0);
    chk("reset_dup", 16'(f.dup_req), 16'h0);
    rst_n = 1'b1;
    step();
    // single line: valid exactly one cycle, two edges after the request
    f.req = 16'h0020; f.out_ready = 1'b1;
    step(); f.req = '0;
    chk_fix("single_e1", 1'b0, 4'd0, 16'h0020);
    step();
    chk_fix("single_e2", 1'b1, 4'd5, 16'h0020);
    step();
    chk_fix("single_e3", 1'b0, 4'd0, 16'h0000);
    // fixed priority: each retired bit matches the decoded code
    f.req = 16'h8421;
    step(); f.req = '0;
    chk_fix("fix_e1", 1'b0, 4'd0, 16'h8421);
    step(); chk_fix("fix_0", 1'b1, 4'd0, 16'h8421);
    step(); chk_fix("fix_5", 1'b1, 4'd5, 16'h8420);
    step(); chk_fix("fix_10", 1'b1, 4'd10, 16'h8400);
    step(); chk_fix("fix_15", 1'b1, 4'd15, 16'h8000);
    step(); chk_fix("fix_done", 1'b0, 4'd0, 16'h0000);
    // backpressure: presented code is held while a higher-priority line arrives
    f.out_ready = 1'b0; f.req = 16'h0010;
    step(); f.req = '0;
    step(); chk_fix("bp_present", 1'b1, 4'd4, 16'h0010);
    f.req = 16'h0001;
    step(); f.req = '0;
    chk_fix("bp_hold1", 1'b1, 4'd4, 16'h0011);
    step(); chk_fix("bp_hold2", 1'b1, 4'd4, 16'h0011);
    f.out_ready = 1'b1;
    step(); chk_fix("bp_next", 1'b1, 4'd0, 16'h0001);
    step(); chk_fix("bp_done", 1'b0, 4'd0, 16'h0000);
    // duplicate request and same-cycle re-request on accept
    f.out_ready = 1'b0; f.req = 16'h0080;
    step();
    chk("dup_first", 16'(f.dup_req), 16'h0);
    step(); f.req = '0;
    chk("dup_pulse", 16'(f.dup_req), 16'h1);
    chk_fix("dup_present", 1'b1, 4'd7, 16'h0080);
    step();
    chk("dup_clear", 16'(f.dup_req), 16'h0);
    f.out_ready = 1'b1; f.req = 16'h0080;
    step(); f.req = '0;
    chk("same_nodup", 16'(f.dup_req), 16'h0);
    chk_fix("same_keep", 1'b0, 4'd0, 16'h0080);
    step(); chk_fix("same_again", 1'b1, 4'd7, 16'h0080);
    step(); chk_fix("same_done", 1'b0, 4'd0, 16'h0000);
    // all 16 lines: one code per cycle then idle
    f.req = 16'hFFFF;
    step(); f.req = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_fix($sformatf("burst_%0d", i), 1'b1, 4'(i), 16'hFFFF << i);
    end
    step(); chk_fix("burst_done", 1'b0, 4'd0, 16'h0000);
    // rotating priority: lines 3 and 9 re-requested on each accept
    r.out_ready = 1'b1; r.req = 16'h0208;
    step(); r.req = '0;
    chk_rr("rr_e1", 1'b0, 4'd0);
    step(); chk_rr("rr_a0", 1'b1, 4'd3);
    r.req = 16'h0008;
    step(); chk_rr("rr_a1", 1'b1, 4'd9);
    r.req = 16'h0200;
    step(); chk_rr("rr_a2", 1'b1, 4'd3);
    r.req = 16'h0008;
    step(); chk_rr("rr_a3", 1'b1, 4'd9);
    r.req = '0;
    step(); chk_rr("rr_drain3", 1'b1, 4'd3);
    step(); chk_rr("rr_idle", 1'b0, 4'd0);
    chk("rr_pend0", r.pending, 16'h0000);
    // pointer now 4: line 15 first, then wrap leaves 5 ahead of 1
    r.out_ready = 1'b0; r.req = 16'h8000;
    step(); r.req = '0;
    step(); chk_rr("rr_p15", 1'b1, 4'd15);
    r.req = 16'h0022;
    step(); r.req = '0;
    chk_rr("rr_hold15", 1'b1, 4'd15);
    r.out_ready = 1'b1;
    step(); chk_rr("rr_p5", 1'b1, 4'd5);
    step(); chk_rr("rr_p1", 1'b1, 4'd1);
    step(); chk_rr("rr_end", 1'b0, 4'd0);
    r.out_ready = 1'b0;
    // asynchronous reset with all lines pending
    f.out_ready = 1'b0; f.req = 16'hFFFF;
    step(); f.req = '0;
    step(); chk_fix("pre_rst", 1'b1, 4'd0, 16'hFFFF);
    #3 rst_n = 1'b0;
    #1;
    chk_fix("async_rst", 1'b0, 4'd0, 16'h0000);
    chk("async_rst_idx", 16'(f.out_idx), 16'h0);
    step(); rst_n = 1'b1;
    f.out_ready = 1'b1;
    step(); step();
    chk_fix("post_rst", 1'b0, 4'd0, 16'h0000);
    f.req = 16'h0002;
    step(); f.req = '0;
    step(); chk_fix("post_rst_req", 1'b1, 4'd1, 16'h0002);
    step(); chk_fix("post_rst_done", 1'b0, 4'd0, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
